id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core. Sits directly downstream of control_unit and the register file read.
- Latches decoded control signals and operands for EX, and selects the destination register.
- Inserts bubbles for load-use hazards and branch flushes.
- Serialises SYSCALL through a drain FSM that emits a one-cycle syscall_fire once older instructions retire.

---
 rtl/id_ex_stage_pkg.sv | 18 +
 rtl/id_ex_stage_hazard_detect.sv | 17 +
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 tb/tb_id_ex_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: drain FSM encodings,
// the link register ID and field widths of the EX-side bundle.
package id_ex_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EXEC  = 2'd2
  } drain_state_t;

  localparam int REG_ID_W = 5;
  localparam int ALU_OP_W = 4;
  localparam int SHAMT_W  = 5;

  localparam logic [REG_ID_W-1:0] REG_RA   = 5'd31;
  localparam logic [REG_ID_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID. Writes aimed at $0 never raise a hazard.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic                ex_mem_to_reg,
  input  logic [REG_ID_W-1:0] ex_write_reg,
  input  logic [REG_ID_W-1:0] id_rs,
  input  logic [REG_ID_W-1:0] id_rt,
  output logic                load_use
);

  assign load_use = ex_mem_to_reg
                  && (ex_write_reg != REG_ZERO)
                  && ((ex_write_reg == id_rs) || (ex_write_reg == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and flush bubbles, plus a drain FSM
// that serialises SYSCALL and emits a one-cycle syscall_fire.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dest,
  input  logic                  id_jump_link,
  input  logic                  id_syscall,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic [DATA_WIDTH-1:0] id_rs_data,
  input  logic [DATA_WIDTH-1:0] id_rt_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [REG_ID_W-1:0]   id_rs,
  input  logic [REG_ID_W-1:0]   id_rt,
  input  logic [REG_ID_W-1:0]   id_rd,
  input  logic [SHAMT_W-1:0]    id_shamt,
  input  logic                  flush,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [DATA_WIDTH-1:0] ex_rs_data,
  output logic [DATA_WIDTH-1:0] ex_rt_data,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [REG_ID_W-1:0]   ex_rs,
  output logic [REG_ID_W-1:0]   ex_rt,
  output logic [REG_ID_W-1:0]   ex_write_reg,
  output logic [SHAMT_W-1:0]    ex_shamt,
  output logic                  stall_id,
  output logic                  syscall_fire,
  output logic                  drain_busy,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  // Handshake: ID has no valid/ready pair. The stage accepts the ID
  // instruction on a rising edge exactly when capture is high; stall_id
  // tells upstream to hold it, and flush discards it without holding.

  drain_state_t         state, next_state;
  logic [CNT_W-1:0]     cnt, next_cnt;
  logic                 load_use;
  logic                 capture;
  logic [REG_ID_W-1:0]  dest_reg;

  hazard_detect u_hazard_detect (
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_write_reg  (ex_write_reg),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .load_use      (load_use)
  );

  assign dest_reg   = id_jump_link ? REG_RA : (id_reg_dest ? id_rd : id_rt);
  assign drain_busy = (state != ST_IDLE);
  assign dbg_state  = state;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    capture    = 1'b0;
    stall_id   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flush) begin
          // killed instruction: bubble, and ID moves on
        end else if (load_use) begin
          stall_id = 1'b1;
        end else if (id_syscall) begin
          stall_id   = 1'b1;
          next_state = ST_DRAIN;
          next_cnt   = CNT_W'(DRAIN_CYCLES);
        end else begin
          capture = 1'b1;
        end
      end
      ST_DRAIN: begin
        stall_id = 1'b1;
        next_cnt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) next_state = ST_EXEC;
      end
      ST_EXEC: begin
        // SYSCALL still sits in ID; release it without issuing it to EX
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      syscall_fire  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_write_reg  <= '0;
      ex_shamt      <= '0;
    end else begin
      state        <= next_state;
      cnt          <= next_cnt;
      syscall_fire <= (next_state == ST_EXEC);
      if (capture) begin
        ex_reg_write  <= id_reg_write;
        ex_mem_to_reg <= id_mem_to_reg;
        ex_mem_write  <= id_mem_write;
        ex_alu_src    <= id_alu_src;
        ex_alu_op     <= id_alu_op;
        ex_rs_data    <= id_rs_data;
        ex_rt_data    <= id_rt_data;
        ex_imm        <= id_imm;
        ex_rs         <= id_rs;
        ex_rt         <= id_rt;
        ex_write_reg  <= dest_reg;
        ex_shamt      <= id_shamt;
      end else begin
        ex_reg_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_alu_op     <= '0;
        ex_rs_data    <= '0;
        ex_rt_data    <= '0;
        ex_imm        <= '0;
        ex_rs         <= '0;
        ex_rt         <= '0;
        ex_write_reg  <= '0;
        ex_shamt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors, a cycle-level reference model
// checked every cycle, and hand-computed literal checks.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int DC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src;
  logic id_reg_dest, id_jump_link, id_syscall, flush;
  logic [3:0] id_alu_op;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0] id_rs, id_rt, id_rd, id_shamt;
  logic ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src;
  logic [3:0] ex_alu_op;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_write_reg, ex_shamt;
  logic stall_id, syscall_fire, drain_busy;
  logic [1:0] dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(DW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_dest(id_reg_dest), .id_jump_link(id_jump_link),
    .id_syscall(id_syscall), .id_alu_op(id_alu_op),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .flush(flush),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_write_reg(ex_write_reg), .ex_shamt(ex_shamt),
    .stall_id(stall_id), .syscall_fire(syscall_fire),
    .drain_busy(drain_busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  int fire_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic reg_write, mem_to_reg, mem_write, alu_src;
    logic [3:0] alu_op;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [4:0] rs, rt, write_reg, shamt;
  } ex_t;

  ex_t m_ex;
  int  m_wait = 0;      // cycles left until (and including) the fire cycle
  bit  m_live = 1'b0;

  function automatic ex_t bubble();
    ex_t b;
    b.reg_write = 0; b.mem_to_reg = 0; b.mem_write = 0; b.alu_src = 0;
    b.alu_op = 0; b.rs_data = 0; b.rt_data = 0; b.imm = 0;
    b.rs = 0; b.rt = 0; b.write_reg = 0; b.shamt = 0;
    return b;
  endfunction

  function automatic ex_t from_id();
    ex_t e;
    e.reg_write = id_reg_write; e.mem_to_reg = id_mem_to_reg;
    e.mem_write = id_mem_write; e.alu_src = id_alu_src;
    e.alu_op = id_alu_op; e.rs_data = id_rs_data; e.rt_data = id_rt_data;
    e.imm = id_imm; e.rs = id_rs; e.rt = id_rt; e.shamt = id_shamt;
    if (id_jump_link) e.write_reg = 5'd31;
    else if (id_reg_dest) e.write_reg = id_rd;
    else e.write_reg = id_rt;
    return e;
  endfunction

  function automatic bit m_load_use();
    return m_ex.mem_to_reg && (m_ex.write_reg != 0) &&
           (m_ex.write_reg == id_rs || m_ex.write_reg == id_rt);
  endfunction

  function automatic bit m_stall();
    if (m_wait > 1) return 1'b1;
    if (m_wait == 1) return 1'b0;
    if (flush) return 1'b0;
    return m_load_use() || id_syscall;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ex <= bubble();
      m_wait <= 0;
    end else if (m_wait > 0) begin
      m_ex <= bubble();
      m_wait <= m_wait - 1;
    end else if (flush || m_load_use()) begin
      m_ex <= bubble();
    end else if (id_syscall) begin
      m_ex <= bubble();
      m_wait <= DC + 1;
    end else begin
      m_ex <= from_id();
    end
    m_live <= 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      chk("ex_reg_write", ex_reg_write, m_ex.reg_write);
      chk("ex_mem_to_reg", ex_mem_to_reg, m_ex.mem_to_reg);
      chk("ex_mem_write", ex_mem_write, m_ex.mem_write);
      chk("ex_alu_src", ex_alu_src, m_ex.alu_src);
      chk("ex_alu_op", ex_alu_op, m_ex.alu_op);
      chk("ex_rs_data", ex_rs_data, m_ex.rs_data);
      chk("ex_rt_data", ex_rt_data, m_ex.rt_data);
      chk("ex_imm", ex_imm, m_ex.imm);
      chk("ex_rs", ex_rs, m_ex.rs);
      chk("ex_rt", ex_rt, m_ex.rt);
      chk("ex_write_reg", ex_write_reg, m_ex.write_reg);
      chk("ex_shamt", ex_shamt, m_ex.shamt);
      chk("stall_id", stall_id, m_stall());
      chk("syscall_fire", syscall_fire, m_wait == 1);
      chk("drain_busy", drain_busy, m_wait > 0);
      chk("flush_during_drain", flush && (m_wait > 0), 1'b0);
      if (syscall_fire === 1'b1) fire_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    id_reg_write = 0; id_mem_to_reg = 0; id_mem_write = 0; id_alu_src = 0;
    id_reg_dest = 0; id_jump_link = 0; id_syscall = 0; flush = 0;
    id_alu_op = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0;
  endtask

  task automatic drive_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [3:0] op, input logic [DW-1:0] rs_d, input logic [DW-1:0] rt_d);
    drive_nop();
    id_reg_write = 1; id_reg_dest = 1; id_alu_op = op;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rs_d; id_rt_data = rt_d;
  endtask

  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [DW-1:0] imm);
    drive_nop();
    id_reg_write = 1; id_mem_to_reg = 1; id_alu_src = 1; id_alu_op = 4'h2;
    id_rs = rs; id_rt = rt; id_rd = 5'd0; id_imm = imm;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_nop();
    rst_n = 0;
    cycle();
    cycle();
    rst_n = 1;
    @(negedge clk);
    chk("reset_ex_reg_write", ex_reg_write, 0);
    chk("reset_ex_write_reg", ex_write_reg, 0);
    chk("reset_drain_busy", drain_busy, 0);
    chk("reset_syscall_fire", syscall_fire, 0);

    // reset in the middle of a drain drops the syscall
    id_syscall = 1;
    cycle();                 // DRAIN, counter 3
    cycle();                 // DRAIN, counter 2
    @(negedge clk);
    chk("middrain_busy", drain_busy, 1);
    rst_n = 0;
    cycle();
    rst_n = 1;
    id_syscall = 0;
    @(negedge clk);
    chk("post_reset_busy", drain_busy, 0);
    chk("post_reset_reg_write", ex_reg_write, 0);
    chk("post_reset_fire", syscall_fire, 0);
    repeat (6) cycle();
    chk("no_fire_after_reset", fire_cnt, 0);

    // plain R-type capture
    drive_rtype(5'd3, 5'd7, 5'd5, 4'h2, 32'h10, 32'h20);
    @(negedge clk);
    chk("rtype_stall", stall_id, 0);
    cycle();
    @(negedge clk);
    chk("rtype_write_reg", ex_write_reg, 5);
    chk("rtype_alu_op", ex_alu_op, 2);
    chk("rtype_rs_data", ex_rs_data, 32'h10);
    chk("rtype_reg_write", ex_reg_write, 1);

    // load-use stall and replay
    drive_lw(5'd2, 5'd8, 32'h4);
    cycle();
    drive_rtype(5'd8, 5'd9, 5'd10, 4'h2, 32'h1, 32'h2);
    @(negedge clk);
    chk("lu_stall", stall_id, 1);
    chk("lu_ex_write_reg", ex_write_reg, 8);
    cycle();
    @(negedge clk);
    chk("lu_bubble_reg_write", ex_reg_write, 0);
    chk("lu_bubble_write_reg", ex_write_reg, 0);
    chk("lu_replay_stall", stall_id, 0);
    cycle();
    @(negedge clk);
    chk("lu_replay_write_reg", ex_write_reg, 10);
    chk("lu_replay_reg_write", ex_reg_write, 1);

    // load into $0 never stalls
    drive_lw(5'd2, 5'd0, 32'h8);
    cycle();
    drive_rtype(5'd0, 5'd0, 5'd11, 4'h1, 32'h3, 32'h4);
    @(negedge clk);
    chk("zero_no_stall", stall_id, 0);
    cycle();
    @(negedge clk);
    chk("zero_captured", ex_write_reg, 11);

    // flush beats load-use and syscall
    drive_lw(5'd2, 5'd8, 32'hC);
    cycle();
    drive_rtype(5'd8, 5'd1, 5'd12, 4'h3, 32'h5, 32'h6);
    id_syscall = 1;
    flush = 1;
    @(negedge clk);
    chk("flush_stall", stall_id, 0);
    cycle();
    drive_nop();
    @(negedge clk);
    chk("flush_bubble", ex_reg_write, 0);
    chk("flush_write_reg", ex_write_reg, 0);
    chk("flush_no_drain", drain_busy, 0);
    cycle();

    // SYSCALL: stall 0-3, fire 4, busy 1-4, bubbles through 5
    drive_nop();
    id_syscall = 1;
    @(negedge clk);
    chk("sys_c0_stall", stall_id, 1);
    for (int k = 1; k <= 5; k++) begin
      cycle();
      @(negedge clk);
      chk("sys_stall", stall_id, (k <= 3) ? 1 : 0);
      chk("sys_fire", syscall_fire, (k == 4) ? 1 : 0);
      chk("sys_busy", drain_busy, (k <= 4) ? 1 : 0);
      chk("sys_bubble", ex_reg_write, 0);
      if (k == 4) begin
        drive_nop();
        id_reg_write = 1; id_alu_src = 1; id_rt = 5'd12; id_imm = 32'hFFFF_FFF0;
      end
    end
    cycle();
    @(negedge clk);
    chk("post_sys_write_reg", ex_write_reg, 12);
    chk("post_sys_imm", ex_imm, 32'hFFFF_FFF0);
    chk("sys_fire_count", fire_cnt, 1);

    // JAL links to $31 regardless of rd/rt
    drive_nop();
    id_jump_link = 1; id_reg_write = 1; id_reg_dest = 1;
    cycle();
    @(negedge clk);
    chk("jal_write_reg", ex_write_reg, 31);
    chk("jal_reg_write", ex_reg_write, 1);
    id_reg_write = 0;
    cycle();
    @(negedge clk);
    chk("jal_nowrite_reg", ex_write_reg, 31);
    chk("jal_nowrite_en", ex_reg_write, 0);

    // pass-through patterns over every field
    for (int i = 0; i < 4; i++) begin
      drive_nop();
      id_reg_write = i[0]; id_mem_write = i[1]; id_alu_src = ~i[0];
      id_reg_dest = i[1]; id_alu_op = 4'(i * 3 + 1);
      id_rs_data = 32'hA5A5_0000 + i; id_rt_data = 32'h5A5A_0000 + i;
      id_imm = 32'h8000_0000 >> i; id_shamt = 5'(i * 7);
      id_rs = 5'(i + 1); id_rt = 5'(i + 13); id_rd = 5'(i + 20);
      cycle();
    end
    drive_nop();
    @(negedge clk);
    chk("pat_shamt", ex_shamt, 21);
    chk("pat_write_reg", ex_write_reg, 23);
    chk("pat_imm", ex_imm, 32'h1000_0000);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
